// File: rtl/mul_div_unit.sv
// Iterative WIDTH-bit multiply/divide unit.
// Multiply is shift-add and divide is restoring; each takes WIDTH iterations.
// The 2*WIDTH-bit result lands in HI/LO. A one-cycle writeback request
// (wb_data/wb_rd/wb_we) then drives the register file write port.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic [WIDTH-1:0] wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_we
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;   // negate product / quotient
  logic               neg_rem;   // remainder follows dividend sign
  logic               dz;        // divisor was zero
  logic               dz_q;      // div_zero flag of the last completed op
  logic [WIDTH-1:0]   b_mag;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   a_orig;    // dividend kept for the divide-by-zero result
  logic [4:0]         rd_q;
  // Multiply: {acc, multiplier}. Divide: {rem, quot}.
  logic [2*WIDTH-1:0] pr;

  // Operand sign handling at acceptance.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  // One iteration of the datapath, plus the finished result.
  logic [WIDTH:0]     mul_add;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_sh;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fin_hi, fin_lo;
  logic               last;

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign wb_we    = done;
  assign wb_data  = lo;
  assign div_zero = done & dz_q;
  assign last     = (cnt == CW'(WIDTH - 1));

  // Magnitudes and sign flags of the incoming operands (signed ops only).
  always_comb begin
    a_neg    = op[0] & src_a[WIDTH-1];
    b_neg    = op[0] & src_b[WIDTH-1];
    a_mag_in = a_neg ? -src_a : src_a;
    b_mag_in = b_neg ? -src_b : src_b;
  end

  // Single shift-add or restoring-divide iteration.
  always_comb begin
    // The 33-bit add keeps the carry, which moves into the accumulator MSB on the shift.
    mul_add  = {1'b0, pr[2*WIDTH-1:WIDTH]} + (pr[0] ? {1'b0, b_mag} : '0);
    div_sh   = {pr[2*WIDTH-2:0], 1'b0};
    div_rem  = pr[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, b_mag};
    if (!is_div)
      step = {mul_add, pr[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      step = div_sh;
    else
      step = {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
  end

  // Sign correction and divide-by-zero override on the final iteration.
  always_comb begin
    prod_fix = neg_res ? -step : step;
    fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (dz) begin
        fin_hi = a_orig;
        fin_lo = '1;
      end else begin
        fin_hi = neg_rem ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
        fin_lo = neg_res ? -step[WIDTH-1:0] : step[WIDTH-1:0];
      end
    end
  end

  // Control FSM, iteration datapath and HI/LO result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      dz_q    <= 1'b0;
      b_mag   <= '0;
      a_orig  <= '0;
      rd_q    <= '0;
      pr      <= '0;
      hi      <= '0;
      lo      <= '0;
      wb_rd   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div  <= op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dz      <= op[1] & (src_b == '0);
            b_mag   <= b_mag_in;
            a_orig  <= src_a;
            rd_q    <= rd_in;
            pr      <= {{WIDTH{1'b0}}, a_mag_in};
            cnt     <= '0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          pr  <= step;
          if (last) begin
            hi    <= fin_hi;
            lo    <= fin_lo;
            wb_rd <= rd_q;
            dz_q  <= dz;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
